multi_ch_sampler: RTL
=====================

# multi_ch_sampler

Parametrised, multi-channel serial-frame sampler for the controller/link serial path. Per channel, it oversamples an asynchronous serial line on `sample_phase` ticks and detects start bits with false-start rejection. It votes each bit near mid-period, checks the stop bit and delivers `DATA_W`-bit frames through a per-channel valid/ready holding register. It sits between the pad-side serial inputs and the game-logic command decoder, and replaces the single-bit fixed-window sampler.

## Interface
- `CHANNELS`, default 2: number of independent serial lanes.
- `DATA_W`, default 8: data bits per frame, LSB first.
- `OSR`, default 8: ticks per bit period; must be even and ≥ 4.
- `sc_clk_ctrl`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `sample_phase`, input, 1: oversampling tick, shared by all lanes; counting and sampling advance only on cycles where it is high.
- `data_in`, input, `CHANNELS`: raw serial lines, idle high, asynchronous.
- `frame_data`, output, `CHANNELS*DATA_W`: lane *n* occupies bits `[n*DATA_W +: DATA_W]`.
- `frame_valid`, output, `CHANNELS`: holding register full.
- `frame_ready`, input, `CHANNELS`: consumer accepts.
- `framing_err`, output, `CHANNELS`: one-cycle pulse when the stop bit is 0.
- `overrun`, output, `CHANNELS`: one-cycle pulse when a completed frame is dropped.

## Operation
- **Synchroniser.** Each `data_in` bit passes through a 2-flop synchroniser. Both flops reset to 1. All lane logic uses the synchronised bit `s`.
- **Tick index.** Each bit period is split into tick indices 0..OSR-1. Let M = OSR/2. Vote samples are taken at indices M-1, M and M+1. The vote result is the majority of these 3 samples.
- **Lane FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:** a tick with s=0 enters START. That tick is index 0 of the start bit.
- **START:**
  - At index M+1, vote = 1 → false start, go to IDLE with no flags.
  - Otherwise, at index OSR-1, go to DATA with bit count 0.
- **DATA:**
  - At index OSR-1, shift the vote in, LSB first, and increment the bit count.
  - After bit DATA_W-1, go to STOP.
- **STOP:** decide at index M+1.
  - Vote = 1 → frame complete, go to IDLE.
  - Vote = 0 → pulse `framing_err`, discard the frame, go to WAIT_HIGH.
- **WAIT_HIGH:** a tick with s=1 returns to IDLE. This prevents a held-low line from being read as a continuous stream of start bits.
- **Holding register, per lane:**
  - Frame complete and `frame_valid`=0 → load `frame_data`, set `frame_valid`.
  - Transfer occurs on any edge where `frame_valid` and `frame_ready` are both 1. `frame_valid` clears unless a frame completes on the same edge. In that case the new frame loads and `frame_valid` stays 1.
  - Frame complete while `frame_valid`=1 and `frame_ready`=0 → pulse `overrun`. The new frame is dropped and the held data is unchanged.
- **Lane independence.** Lanes are fully independent; only `sample_phase` is shared.
- **Counters.** The tick counter is ⌈log2 OSR⌉ bits and the bit counter is ⌈log2(DATA_W+1)⌉ bits. Both are cleared on every state entry. Neither ever wraps mid-period.

## Timing
- **Reset values:** all outputs are 0, all FSMs are IDLE, all counters are 0, and the synchronisers are 1.
- **Reset mid-frame** aborts immediately. No flags are raised and partial data is lost.
- **Flag and data updates** are registered: `framing_err`, `overrun`, `frame_valid` and `frame_data` update on the edge of the deciding tick.
- **Latency with `sample_phase` tied high.** Call edge 0 the first edge at which `data_in`=0 is captured. Then:
  - Index 0 of the start bit is at edge 2.
  - `frame_valid` rises after edge 2 + OSR·(DATA_W+1) + M + 1, which is edge 79 at the default parameters.
- **Other `sample_phase` rates:** latency scales with tick spacing. Synchroniser latency is unaffected, because it runs every cycle.
- **Handshake rules:**
  - `frame_ready` may be asserted at any time.
  - `frame_data` is stable whenever `frame_valid`=1.

## Configuration
- **`SAMPLER_MAJORITY_EN` defined:** 3-sample majority vote as described above.
- **`SAMPLER_MAJORITY_EN` undefined:**
  - The vote is the single sample at index M.
  - The false-start and stop decisions move to index M.
  - `frame_valid` latency is one tick shorter (edge 78 at the default parameters).
  - No vote registers are built.

## Structure
- **Package `sampler_pkg`** holds:
  - the lane state encoding (IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4; 3 bits);
  - the vote-index helper constants derived from OSR;
  - the parameter legality check for OSR even and ≥ 4.
- **Sub-module `sampler_lane`** holds one synchroniser, FSM, counters, shift register and holding register. The top level generates `CHANNELS` instances and concatenates their outputs.

## Test plan
All scenarios use the default parameters (CHANNELS=2, OSR=8, DATA_W=8) and `sample_phase`=1 unless stated.
1. **Nominal frame.** Send frame 0xA5 on lane 0 with `frame_ready`=1 → `frame_data[7:0]`=0xA5. `frame_valid[0]` is high for exactly 1 cycle, after edge 79. Lane 1 stays quiet.
2. **False start.** Drive lane 0 low for 3 cycles, then high → no `frame_valid`, no `framing_err`, FSM returns to IDLE. A following 0x3C frame is received correctly.
3. **Framing error.** Send 0x55 with the stop bit 0, holding the line low for 20 more cycles → one-cycle `framing_err[0]` and no `frame_valid`. A following 0x81 frame is received once the line has returned high.
4. **Overrun.** With `frame_ready[1]`=0, send 0x11 then 0x22 on lane 1 → `frame_data[15:8]`=0x11 is retained and `overrun[1]` pulses once. Raising ready then gives one transfer of 0x11 only.
5. **Slow ticks and reset.** With `sample_phase` high every 4th cycle, 0xC3 is received with 4× latency. Asserting `reset` mid-data-bit 4 of a second frame → all outputs go to 0 and no flags are raised. The next 0x0F frame is received correctly.
6. **Majority vote.** Apply a one-cycle inverted glitch at index M of data bit 2 of 0xFF → the frame reads 0xFF with `SAMPLER_MAJORITY_EN` defined and 0xFB without it.

Source files
------------

// File: rtl/sampler_pkg.sv
// Lane-state encoding and OSR-derived sampling indices for the multi-channel serial sampler.
// SAMPLER_MAJORITY_EN selects the 3-sample vote and moves decisions from index M to M+1.
package sampler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } lane_state_e;

  function automatic int vote_mid(input int osr);
    return osr / 2;
  endfunction

  // Tick index at which false-start and stop decisions are taken.
  function automatic int decide_idx(input int osr);
`ifdef SAMPLER_MAJORITY_EN
    return osr / 2 + 1;
`else
    return osr / 2;
`endif
  endfunction

  function automatic bit osr_legal(input int osr);
    return (osr >= 4) && (osr % 2 == 0);
  endfunction

endpackage

// File: rtl/multi_ch_sampler_if.sv
// Serial-in / framed-out bundle between pads, the sampler and the command decoder.
interface multi_ch_sampler_if #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8
);
  logic                         sample_phase;
  logic [CHANNELS-1:0]          data_in;
  logic [CHANNELS*DATA_W-1:0]   frame_data;
  logic [CHANNELS-1:0]          frame_valid;
  logic [CHANNELS-1:0]          frame_ready;
  logic [CHANNELS-1:0]          framing_err;
  logic [CHANNELS-1:0]          overrun;

  modport master (
    output sample_phase, data_in, frame_ready,
    input  frame_data, frame_valid, framing_err, overrun
  );

  modport slave (
    input  sample_phase, data_in, frame_ready,
    output frame_data, frame_valid, framing_err, overrun
  );
endinterface

// File: rtl/sampler_lane.sv
// One serial lane: synchroniser, start/data/stop FSM, bit vote and valid/ready holding register.
// SAMPLER_MAJORITY_EN builds the two vote flops; otherwise the mid-bit sample alone is used.
module sampler_lane
  import sampler_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 8
) (
  input  logic              sc_clk_ctrl,
  input  logic              reset,
  input  logic              sample_phase,
  input  logic              data_in,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_valid,
  output logic              framing_err,
  output logic              overrun
);
  localparam int CW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(OSR - 1);
  localparam logic [CW-1:0] IDX_DEC  = CW'(decide_idx(OSR));

  if (!osr_legal(OSR)) begin : g_bad_osr
    $error("sampler_lane: OSR must be even and >= 4");
  end

  lane_state_e       state, nxt_state;
  logic [1:0]        sync;
  logic [CW-1:0]     tick_cnt, nxt_tick, idx;
  logic [BW-1:0]     bit_cnt, nxt_bit;
  logic [DATA_W-1:0] shreg, nxt_sh;
  logic              s, samp, vote, in_bit, done, ferr;

  assign s = sync[1];
  // The IDLE tick that sees s=0 already consumed index 0 of the start bit.
  assign idx = tick_cnt + CW'(state == START);

`ifdef SAMPLER_MAJORITY_EN
  localparam logic [CW-1:0] IDX_LO  = CW'(vote_mid(OSR) - 1);
  localparam logic [CW-1:0] IDX_MID = CW'(vote_mid(OSR));
  logic v_lo, v_mid;

  always_ff @(posedge sc_clk_ctrl or posedge reset) begin
    if (reset) begin
      v_lo  <= 1'b1;
      v_mid <= 1'b1;
    end else if (sample_phase) begin
      if (idx == IDX_LO)  v_lo  <= s;
      if (idx == IDX_MID) v_mid <= s;
    end
  end

  assign vote = (v_lo & v_mid) | (v_lo & s) | (v_mid & s);
`else
  assign vote = s;
`endif

  // When the decision index is also the last index the held sample is not yet updated.
  assign in_bit = (idx == IDX_DEC) ? vote : samp;

  always_comb begin
    nxt_state = state;
    nxt_tick  = tick_cnt;
    nxt_bit   = bit_cnt;
    nxt_sh    = shreg;
    done      = 1'b0;
    ferr      = 1'b0;
    if (sample_phase) begin
      nxt_tick = tick_cnt + CW'(1);
      case (state)
        IDLE: begin
          nxt_tick = '0;
          if (!s) nxt_state = START;
        end
        START: begin
          if (idx == IDX_DEC && vote) nxt_state = IDLE;
          else if (idx == IDX_LAST)   nxt_state = DATA;
        end
        DATA: begin
          if (idx == IDX_LAST) begin
            nxt_tick = '0;
            nxt_sh   = {in_bit, shreg[DATA_W-1:1]};
            nxt_bit  = bit_cnt + BW'(1);
            if (bit_cnt == BW'(DATA_W - 1)) nxt_state = STOP;
          end
        end
        STOP: begin
          if (idx == IDX_DEC) begin
            if (vote) begin
              done      = 1'b1;
              nxt_state = IDLE;
            end else begin
              ferr      = 1'b1;
              nxt_state = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          nxt_tick = '0;
          if (s) nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
      if (nxt_state != state) begin
        nxt_tick = '0;
        nxt_bit  = '0;
      end
    end
  end

  always_ff @(posedge sc_clk_ctrl or posedge reset) begin
    if (reset) begin
      sync     <= 2'b11;
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      samp     <= 1'b0;
    end else begin
      sync     <= {sync[0], data_in};
      state    <= nxt_state;
      tick_cnt <= nxt_tick;
      bit_cnt  <= nxt_bit;
      shreg    <= nxt_sh;
      if (sample_phase && idx == IDX_DEC) samp <= vote;
    end
  end

  // A completing frame may load on the same edge the old one is taken.
  always_ff @(posedge sc_clk_ctrl or posedge reset) begin
    if (reset) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= ferr;
      overrun     <= done & frame_valid & ~frame_ready;
      if (done && (!frame_valid || frame_ready)) begin
        frame_data  <= shreg;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_ch_sampler.sv
// Multi-channel serial-frame sampler: CHANNELS independent lanes sharing one sample_phase tick.
// Vote style is selected per build by SAMPLER_MAJORITY_EN inside each lane.
module multi_ch_sampler
  import sampler_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8,
  parameter int OSR      = 8
) (
  input  logic              sc_clk_ctrl,
  input  logic              reset,
  multi_ch_sampler_if.slave bus
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    sampler_lane #(
      .DATA_W (DATA_W),
      .OSR    (OSR)
    ) u_lane (
      .sc_clk_ctrl  (sc_clk_ctrl),
      .reset        (reset),
      .sample_phase (bus.sample_phase),
      .data_in      (bus.data_in[n]),
      .frame_ready  (bus.frame_ready[n]),
      .frame_data   (bus.frame_data[n*DATA_W +: DATA_W]),
      .frame_valid  (bus.frame_valid[n]),
      .framing_err  (bus.framing_err[n]),
      .overrun      (bus.overrun[n])
    );
  end

endmodule
